// File: rtl/fwvip_wb_target_mem.sv
// Wishbone classic target backed by a small register-file memory with optional wait states.
// Responses are registered: a request accepted at edge k terminates between edges k+1+WAIT_STATES and k+2+WAIT_STATES.
`timescale 1ns/1ps
module fwvip_wb_target_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   adr,
  input  logic [DATA_WIDTH-1:0]   dat_w,
  output logic [DATA_WIDTH-1:0]   dat_r,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic                    stb,
  input  logic                    cyc,
  output logic                    ack,
  output logic                    err
);

  localparam int NSEL = DATA_WIDTH / 8;
  localparam int LSB  = $clog2(NSEL);
  localparam int IDX  = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  accept;

  logic [ADDR_WIDTH-1:0] word;
  logic                  in_range;
  logic [IDX-1:0]        idx;

  logic [IDX-1:0]        idx_q;
  logic                  oor_q;
  logic                  we_q;
  logic [NSEL-1:0]       sel_q;
  logic [DATA_WIDTH-1:0] dat_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Sub-word address bits are shifted away; anything above the array is out of range.
  always_comb begin
    word     = adr >> LSB;
    in_range = ((word >> IDX) == '0);
    idx      = word[IDX-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (cyc && stb) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (!cyc) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt <= 4'd1) begin
          state_nxt = RESP;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = 4'(cnt - 4'd1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      oor_q <= 1'b0;
      we_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
    end else if (accept) begin
      idx_q <= idx;
      oor_q <= !in_range;
      we_q  <= we;
      sel_q <= sel;
      dat_q <= dat_w;
    end
  end

  // The RESP edge both commits the write and raises the termination pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ack   <= 1'b0;
      err   <= 1'b0;
      dat_r <= '0;
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else begin
      ack   <= 1'b0;
      err   <= 1'b0;
      dat_r <= '0;
      if (state == RESP) begin
        if (oor_q) begin
          err <= 1'b1;
        end else begin
          ack <= 1'b1;
          if (we_q) begin
            for (int i = 0; i < NSEL; i++) begin
              if (sel_q[i]) begin
                mem[idx_q][8*i +: 8] <= dat_q[8*i +: 8];
              end
            end
          end else begin
            dat_r <= mem[idx_q];
          end
        end
      end
    end
  end

endmodule
